// File: rtl/bitonic_sort_inc_1_4_loader_if.sv
// Handshake bundle between the element stream, the frame loader and the sorter inputs.
// master: element producer / frame consumer side; slave: the loader itself.
interface bitonic_sort_inc_1_4_loader_if;
  logic s_valid;
  logic s_ready;
  logic s_data;
  logic s_last;
  logic in_array_0;
  logic in_array_1;
  logic in_array_2;
  logic in_array_3;
  logic f_valid;
  logic f_ready;
  logic f_padded;

  modport master (
    output s_valid, s_data, s_last, f_ready,
    input  s_ready, in_array_0, in_array_1, in_array_2, in_array_3, f_valid, f_padded
  );

  modport slave (
    input  s_valid, s_data, s_last, f_ready,
    output s_ready, in_array_0, in_array_1, in_array_2, in_array_3, f_valid, f_padded
  );
endinterface

// File: rtl/bitonic_sort_inc_1_4_loader.sv
// Packs a 1-bit element stream into padded 4-element frames for the bitonic sorter,
// double-buffered so the next frame fills while the current one is presented.
module bitonic_sort_inc_1_4_loader #(
  parameter logic PAD_VALUE   = 1'b0,
  parameter int   FRAME_CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  bitonic_sort_inc_1_4_loader_if.slave bus,
  output logic [FRAME_CNT_W-1:0]    frame_count
);

  typedef enum logic {FILLING = 1'b0, CLOSED = 1'b1} fill_state_t;

  fill_state_t            fill_state_r;
  fill_state_t            fill_state_s;
  logic [1:0]             idx_r;
  logic [3:0]             fill_buf_r;
  logic                   fill_pad_r;
  logic [3:0]             out_buf_r;
  logic                   out_pad_r;
  logic                   out_full_r;
  logic [FRAME_CNT_W-1:0] frame_count_r;

  logic       s_ready_s;
  logic       accept_s;
  logic       pop_s;
  logic       close_s;
  logic       hand_s;
  logic [3:0] closed_frame_s;
  logic       closed_pad_s;

  // Handshake qualifiers; hand_s means a closing frame goes straight to the output buffer.
  always_comb begin
    accept_s = bus.s_valid && s_ready_s;
    pop_s    = out_full_r && bus.f_ready;
    close_s  = accept_s && ((idx_r == 2'd3) || bus.s_last);
    hand_s   = close_s && (!out_full_r || pop_s);
  end

  // Fill buffer with the incoming element at idx and PAD_VALUE above it (only kept on close).
  always_comb begin
    closed_frame_s = fill_buf_r;
    for (int i = 0; i < 4; i++) begin
      if (i == int'(idx_r)) begin
        closed_frame_s[i] = bus.s_data;
      end else if (i > int'(idx_r)) begin
        closed_frame_s[i] = PAD_VALUE;
      end else begin
        closed_frame_s[i] = fill_buf_r[i];
      end
    end
    closed_pad_s = (idx_r != 2'd3);
  end

  // Fill state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_state_r <= FILLING;
    end else begin
      fill_state_r <= fill_state_s;
    end
  end

  // Fill next state: park a closed frame until the output buffer frees up.
  always_comb begin
    fill_state_s = fill_state_r;
    case (fill_state_r)
      FILLING: begin
        if (close_s && !hand_s) begin
          fill_state_s = CLOSED;
        end else begin
          fill_state_s = FILLING;
        end
      end
      CLOSED: begin
        if (pop_s) begin
          fill_state_s = FILLING;
        end else begin
          fill_state_s = CLOSED;
        end
      end
      default: fill_state_s = FILLING;
    endcase
  end

  // Fill outputs: ready depends only on registered state.
  always_comb begin
    case (fill_state_r)
      FILLING: s_ready_s = 1'b1;
      CLOSED:  s_ready_s = 1'b0;
      default: s_ready_s = 1'b0;
    endcase
  end

  // Fill datapath: index restarts on every close so a parked frame resumes at position 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r      <= 2'd0;
      fill_buf_r <= 4'd0;
      fill_pad_r <= 1'b0;
    end else if (accept_s) begin
      idx_r      <= close_s ? 2'd0 : idx_r + 2'd1;
      fill_buf_r <= closed_frame_s;
      fill_pad_r <= closed_pad_s;
    end else begin
      idx_r      <= idx_r;
      fill_buf_r <= fill_buf_r;
      fill_pad_r <= fill_pad_r;
    end
  end

  // Output buffer and delivered-frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_buf_r     <= 4'd0;
      out_pad_r     <= 1'b0;
      out_full_r    <= 1'b0;
      frame_count_r <= '0;
    end else begin
      if (hand_s) begin
        out_buf_r  <= closed_frame_s;
        out_pad_r  <= closed_pad_s;
        out_full_r <= 1'b1;
      end else if (pop_s && (fill_state_r == CLOSED)) begin
        out_buf_r  <= fill_buf_r;
        out_pad_r  <= fill_pad_r;
        out_full_r <= 1'b1;
      end else if (pop_s) begin
        out_full_r <= 1'b0;
      end else begin
        out_full_r <= out_full_r;
      end
      if (pop_s) begin
        frame_count_r <= frame_count_r + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        frame_count_r <= frame_count_r;
      end
    end
  end

  assign bus.s_ready    = s_ready_s;
  assign bus.in_array_0 = out_buf_r[0];
  assign bus.in_array_1 = out_buf_r[1];
  assign bus.in_array_2 = out_buf_r[2];
  assign bus.in_array_3 = out_buf_r[3];
  assign bus.f_valid    = out_full_r;
  assign bus.f_padded   = out_pad_r;
  assign frame_count    = frame_count_r;

endmodule

// File: tb/tb_bitonic_sort_inc_1_4_loader.sv
// Directed bench for the 1-bit 4-element frame loader: two instances cover both
// PAD_VALUE settings and a narrow frame counter.
module tb_bitonic_sort_inc_1_4_loader;

  logic       clk;
  logic       rst_n;
  logic [7:0] fca;
  logic [1:0] fcb;
  logic [3:0] frame_a;
  logic [3:0] frame_b;
  int         checks;
  int         errors;
  int         fv_count;

  bitonic_sort_inc_1_4_loader_if ia ();
  bitonic_sort_inc_1_4_loader_if ib ();

  bitonic_sort_inc_1_4_loader #(.PAD_VALUE(1'b0), .FRAME_CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave), .frame_count(fca)
  );

  bitonic_sort_inc_1_4_loader #(.PAD_VALUE(1'b1), .FRAME_CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave), .frame_count(fcb)
  );

  // Frames read left to right as in_array_0..3.
  assign frame_a = {ia.in_array_0, ia.in_array_1, ia.in_array_2, ia.in_array_3};
  assign frame_b = {ib.in_array_0, ib.in_array_1, ib.in_array_2, ib.in_array_3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic d, input logic last);
    ia.s_valid = 1'b1;
    ia.s_data  = d;
    ia.s_last  = last;
    tick();
    ia.s_valid = 1'b0;
    ia.s_last  = 1'b0;
  endtask

  task automatic send_b(input logic d, input logic last);
    ib.s_valid = 1'b1;
    ib.s_data  = d;
    ib.s_last  = last;
    tick();
    ib.s_valid = 1'b0;
    ib.s_last  = 1'b0;
  endtask

  function automatic logic pat(input int i);
    return (i % 3) == 0;
  endfunction

  initial begin
    logic [1:0] wrap_exp [4];
    logic [3:0] exp_frame;
    wrap_exp = '{2'd2, 2'd3, 2'd0, 2'd1};
    checks   = 0;
    errors   = 0;
    fv_count = 0;
    ia.s_valid = 1'b0; ia.s_data = 1'b0; ia.s_last = 1'b0; ia.f_ready = 1'b1;
    ib.s_valid = 1'b0; ib.s_data = 1'b0; ib.s_last = 1'b0; ib.f_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) tick();

    chk("rst_f_valid", ia.f_valid, 1'b0);
    chk("rst_frame", frame_a, 4'h0);
    chk("rst_padded", ia.f_padded, 1'b0);
    chk("rst_count", fca, 8'd0);
    chk("rst_s_ready", ia.s_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // Full frame 1,0,1,0.
    send_a(1'b1, 1'b0); send_a(1'b0, 1'b0); send_a(1'b1, 1'b0);
    chk("full_early_valid", ia.f_valid, 1'b0);
    send_a(1'b0, 1'b0);
    chk("full_valid", ia.f_valid, 1'b1);
    chk("full_frame", frame_a, 4'b1010);
    chk("full_padded", ia.f_padded, 1'b0);
    chk("full_count_before", fca, 8'd0);
    tick();
    chk("full_valid_drop", ia.f_valid, 1'b0);
    chk("full_count_after", fca, 8'd1);

    // Short frame 1,1 + s_last, PAD_VALUE=0.
    send_a(1'b1, 1'b0); send_a(1'b1, 1'b1);
    chk("short_valid", ia.f_valid, 1'b1);
    chk("short_frame", frame_a, 4'b1100);
    chk("short_padded", ia.f_padded, 1'b1);
    tick();
    chk("short_count", fca, 8'd2);

    // PAD_VALUE=1 short frame, then narrow counter wrap.
    send_b(1'b0, 1'b1);
    chk("padb_frame", frame_b, 4'b0111);
    chk("padb_padded", ib.f_padded, 1'b1);
    tick();
    chk("wrap_0", fcb, 2'd1);
    for (int k = 0; k < 4; k++) begin
      repeat (4) send_b(k[0], 1'b0);
      chk("wrap_frame", frame_b, {4{k[0]}});
      tick();
      chk("wrap_count", fcb, wrap_exp[k]);
    end

    // Backpressure: 1,1,1,1,0,0,0,0 fill both buffers; 9th element stalls.
    ia.f_ready = 1'b0;
    repeat (4) send_a(1'b1, 1'b0);
    chk("bp_held_frame", frame_a, 4'b1111);
    repeat (3) send_a(1'b0, 1'b0);
    chk("bp_ready_7", ia.s_ready, 1'b1);
    send_a(1'b0, 1'b0);
    chk("bp_ready_8", ia.s_ready, 1'b0);
    ia.s_valid = 1'b1; ia.s_data = 1'b1;
    tick();
    chk("bp_stall_ready", ia.s_ready, 1'b0);
    chk("bp_stable_frame", frame_a, 4'b1111);
    tick();
    chk("bp_stable_frame2", frame_a, 4'b1111);
    chk("bp_stable_valid", ia.f_valid, 1'b1);
    ia.f_ready = 1'b1;
    tick();
    ia.f_ready = 1'b0;
    chk("bp_next_frame", frame_a, 4'b0000);
    chk("bp_next_valid", ia.f_valid, 1'b1);
    chk("bp_ready_back", ia.s_ready, 1'b1);
    chk("bp_count", fca, 8'd3);
    tick();
    ia.s_valid = 1'b0;
    send_a(1'b0, 1'b1);
    chk("bp_parked_ready", ia.s_ready, 1'b0);
    chk("bp_parked_frame", frame_a, 4'b0000);
    ia.f_ready = 1'b1;
    tick();
    chk("bp_tail_frame", frame_a, 4'b1000);
    chk("bp_tail_padded", ia.f_padded, 1'b1);
    chk("bp_tail_ready", ia.s_ready, 1'b1);
    tick();
    chk("bp_drain_valid", ia.f_valid, 1'b0);
    chk("bp_drain_count", fca, 8'd5);

    // Streaming 40 elements.
    for (int i = 0; i < 40; i++) begin
      ia.s_valid = 1'b1;
      ia.s_data  = pat(i);
      tick();
      chk("stream_ready", ia.s_ready, 1'b1);
      chk("stream_valid", ia.f_valid, (i % 4) == 3);
      if (ia.f_valid) fv_count++;
      if ((i % 4) == 3) begin
        exp_frame = {pat(i - 3), pat(i - 2), pat(i - 1), pat(i)};
        chk("stream_frame", frame_a, exp_frame);
      end
    end
    ia.s_valid = 1'b0;
    tick();
    chk("stream_frames", fv_count, 10);
    chk("stream_count", fca, 8'd15);

    // Reset with a held frame and a partial frame.
    ia.f_ready = 1'b0;
    send_a(1'b0, 1'b0); send_a(1'b1, 1'b0); send_a(1'b1, 1'b0); send_a(1'b0, 1'b0);
    send_a(1'b1, 1'b0); send_a(1'b1, 1'b0);
    chk("rmid_held", ia.f_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmid_valid_async", ia.f_valid, 1'b0);
    chk("rmid_count", fca, 8'd0);
    chk("rmid_ready", ia.s_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    send_a(1'b1, 1'b0); send_a(1'b0, 1'b0); send_a(1'b0, 1'b0);
    chk("rmid_partial_valid", ia.f_valid, 1'b0);
    send_a(1'b1, 1'b0);
    chk("rmid_frame", frame_a, 4'b1001);
    chk("rmid_padded", ia.f_padded, 1'b0);
    chk("rmid_fvalid", ia.f_valid, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
